// File: rtl/mac_bank_seq.sv
// Sequencer for the 4-pixel x 9-tap MAC bank: clears accumulators, streams
// channels from the input buffers, then hands out the four pixels.
module mac_bank_seq #(
  parameter int unsigned CH_W    = 8,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned MAC_LAT = 3
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_start,
  input  logic [CH_W-1:0] i_num_ch,
  input  logic            i_feed_hold,
  output logic            o_busy,
  output logic            o_cfg_err,
  output logic            o_buf_rd_en,
  output logic [CH_W-1:0] o_buf_rd_addr,
  output logic            o_acc_clr,
  output logic            o_acc_en,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [1:0]      o_out_sel,
  output logic            o_done
);

  localparam int unsigned LAT = RD_LAT + MAC_LAT;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // Every stage of the delay line except the one currently driving o_acc_en.
  localparam logic [LAT-1:0] PEND_MASK = ~(LAT'(1) << (LAT - 1));

  logic [2:0]      state_q, state_d;
  logic [CH_W-1:0] cnt_q, cnt_d;
  logic [CH_W-1:0] num_q, num_d;
  logic [LAT-1:0]  dly_q, dly_d;
  logic [1:0]      sel_q, sel_d;
  logic            clr_q, valid_q, done_q, busy_q, err_q, err_d;
  logic            rd_en_c;

  // Next-state and issue logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    sel_d   = sel_q;
    err_d   = 1'b0;
    rd_en_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (i_num_ch != '0) begin
            num_d   = i_num_ch;
            state_d = S_CLEAR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        cnt_d   = '0;
        state_d = S_FEED;
      end
      S_FEED: begin
        if (!i_feed_hold) begin
          rd_en_c = 1'b1;
          cnt_d   = cnt_q + CH_W'(1);
          if (cnt_q == num_q - CH_W'(1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        sel_d = 2'd0;
        // Leave once the only in-flight beat is the one accumulating now.
        if ((dly_q & PEND_MASK) == '0) begin
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (valid_q && i_out_ready) begin
          if (sel_q == 2'd3) begin
            sel_d   = 2'd0;
            state_d = S_DONE;
          end else begin
            sel_d = sel_q + 2'd1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    dly_d = (dly_q << 1) | LAT'(rd_en_c);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      num_q   <= '0;
      dly_q   <= '0;
      sel_q   <= 2'd0;
      clr_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      dly_q   <= dly_d;
      sel_q   <= sel_d;
      clr_q   <= (state_d == S_CLEAR);
      valid_q <= (state_d == S_OUT);
      done_q  <= (state_d == S_DONE);
      busy_q  <= (state_d != S_IDLE);
      err_q   <= err_d;
    end
  end

  // The read strobe follows i_feed_hold within the same cycle.
  assign o_buf_rd_en   = rd_en_c;
  assign o_buf_rd_addr = cnt_q;
  assign o_acc_clr     = clr_q;
  assign o_acc_en      = dly_q[LAT-1];
  assign o_out_valid   = valid_q;
  assign o_out_sel     = sel_q;
  assign o_done        = done_q;
  assign o_busy        = busy_q;
  assign o_cfg_err     = err_q;

endmodule

// File: tb/tb_mac_bank_seq.sv
// Scoreboard bench for mac_bank_seq: expected event cycles are queued when a
// tile is launched and checked as the DUT produces them.
module tb_mac_bank_seq;

  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       rstn;
  logic       i_start;
  logic [7:0] i_num_ch;
  logic       i_feed_hold;
  logic       i_out_ready;
  logic       o_busy, o_cfg_err, o_buf_rd_en, o_acc_clr, o_acc_en;
  logic       o_out_valid, o_done;
  logic [7:0] o_buf_rd_addr;
  logic [1:0] o_out_sel;

  mac_bank_seq dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_start      (i_start),
    .i_num_ch     (i_num_ch),
    .i_feed_hold  (i_feed_hold),
    .o_busy       (o_busy),
    .o_cfg_err    (o_cfg_err),
    .o_buf_rd_en  (o_buf_rd_en),
    .o_buf_rd_addr(o_buf_rd_addr),
    .o_acc_clr    (o_acc_clr),
    .o_acc_en     (o_acc_en),
    .o_out_valid  (o_out_valid),
    .i_out_ready  (i_out_ready),
    .o_out_sel    (o_out_sel),
    .o_done       (o_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  int q_clr[$], q_rd_c[$], q_rd_a[$], q_acc[$];
  int q_out_c[$], q_out_s[$], q_done[$], q_err[$];
  int b_lo = 1, b_hi = 0, v_lo = 1, v_hi = 0;
  int h_lo = 1, h_hi = 0, s_lo = 1, s_hi = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int all_outs();
    return int'({o_busy, o_cfg_err, o_buf_rd_en, o_buf_rd_addr, o_acc_clr,
                 o_acc_en, o_out_valid, o_out_sel, o_done});
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Per-cycle hold/ready drive from the active windows.
  initial begin
    i_feed_hold = 1'b0;
    i_out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      i_feed_hold = (cyc >= h_lo && cyc <= h_hi);
      i_out_ready = !(cyc >= s_lo && cyc <= s_hi);
    end
  end

  // Output monitor / scoreboard consumer.
  always @(negedge clk) begin
    check("busy", int'(o_busy), int'(cyc >= b_lo && cyc <= b_hi));
    check("valid", int'(o_out_valid), int'(cyc >= v_lo && cyc <= v_hi));
    if (o_acc_clr || o_acc_en)
      check("clr_acc_excl", int'(o_acc_clr & o_acc_en), 0);
    if (o_acc_clr) begin
      if (q_clr.size() == 0) check("clr_spur", cyc, -1);
      else check("clr_cyc", cyc, q_clr.pop_front());
    end
    if (o_buf_rd_en) begin
      if (q_rd_c.size() == 0) check("rd_spur", cyc, -1);
      else begin
        check("rd_cyc", cyc, q_rd_c.pop_front());
        check("rd_addr", int'(o_buf_rd_addr), q_rd_a.pop_front());
      end
    end
    if (o_acc_en) begin
      if (q_acc.size() == 0) check("acc_spur", cyc, -1);
      else check("acc_cyc", cyc, q_acc.pop_front());
    end
    if (o_out_valid && i_out_ready) begin
      if (q_out_c.size() == 0) check("out_spur", cyc, -1);
      else begin
        check("out_cyc", cyc, q_out_c.pop_front());
        check("out_sel", int'(o_out_sel), q_out_s.pop_front());
      end
    end
    if (o_done) begin
      if (q_done.size() == 0) check("done_spur", cyc, -1);
      else check("done_cyc", cyc, q_done.pop_front());
    end
    if (o_cfg_err) begin
      if (q_err.size() == 0) check("err_spur", cyc, -1);
      else check("err_cyc", cyc, q_err.pop_front());
    end
  end

  task automatic check_drained(input string tag);
    check({tag, "_clr_left"}, q_clr.size(), 0);
    check({tag, "_rd_left"}, q_rd_c.size(), 0);
    check({tag, "_acc_left"}, q_acc.size(), 0);
    check({tag, "_out_left"}, q_out_c.size(), 0);
    check({tag, "_done_left"}, q_done.size(), 0);
    check({tag, "_err_left"}, q_err.size(), 0);
  endtask

  // Launch one tile, queueing every expected event from the timing relations.
  task automatic tile(input string tag, input int n, input int hold_off, input int hold_len,
                      input int stall_off, input int stall_len, input bit poke);
    int s, c, a, last, v0, d;
    s = cyc;
    h_lo = (hold_len > 0) ? s + hold_off : 1;
    h_hi = (hold_len > 0) ? s + hold_off + hold_len - 1 : 0;
    q_clr.push_back(s + 1);
    c = s + 2;
    a = 0;
    last = c;
    while (a < n) begin
      if (!(c >= h_lo && c <= h_hi)) begin
        q_rd_c.push_back(c);
        q_rd_a.push_back(a);
        q_acc.push_back(c + LAT);
        last = c;
        a++;
      end
      c++;
    end
    v0 = last + LAT + 1;
    s_lo = (stall_len > 0) ? v0 + stall_off : 1;
    s_hi = (stall_len > 0) ? v0 + stall_off + stall_len - 1 : 0;
    c = v0;
    for (int k = 0; k < 4; k++) begin
      while (c >= s_lo && c <= s_hi) c++;
      q_out_c.push_back(c);
      q_out_s.push_back(k);
      c++;
    end
    d = c;
    q_done.push_back(d);
    b_lo = s + 1;
    b_hi = d;
    v_lo = v0;
    v_hi = d - 1;
    i_start  = 1'b1;
    i_num_ch = 8'(n);
    tick(1);
    i_start  = 1'b0;
    i_num_ch = 8'hA5;
    if (poke) begin
      wait_until(s + 3);
      i_start  = 1'b1;
      i_num_ch = 8'd7;
      tick(1);
      i_start = 1'b0;
      wait_until(d);
      i_start = 1'b1;
      tick(1);
      i_start = 1'b0;
    end
    wait_until(d + 4);
    check_drained(tag);
  endtask

  initial begin
    int s;
    rstn     = 1'b0;
    i_start  = 1'b0;
    i_num_ch = 8'd0;
    @(negedge clk);
    check("reset_outs", all_outs(), 0);
    tick(2);
    rstn = 1'b1;
    tick(2);

    tile("nominal", 4, 0, 0, 0, 0, 1'b0);
    tile("hold", 3, 3, 2, 0, 0, 1'b0);
    tile("stall", 2, 0, 0, 1, 3, 1'b0);

    s = cyc;
    q_err.push_back(s + 1);
    i_start  = 1'b1;
    i_num_ch = 8'd0;
    tick(1);
    i_start = 1'b0;
    tick(5);
    check_drained("cfg_err");

    tile("poke", 5, 0, 0, 0, 0, 1'b1);
    tile("max_n", 255, 0, 0, 0, 0, 1'b0);
    tile("rand", 6, 2 + int'($urandom_range(0, 4)), int'($urandom_range(1, 5)),
         int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), 1'b0);

    // Reset in DRAIN with three accumulate beats still in flight.
    s = cyc;
    q_clr.push_back(s + 1);
    for (int i = 0; i < 4; i++) begin
      q_rd_c.push_back(s + 2 + i);
      q_rd_a.push_back(i);
    end
    q_acc.push_back(s + 2 + LAT);
    b_lo = s + 1;
    b_hi = s + 2 + LAT;
    i_start  = 1'b1;
    i_num_ch = 8'd4;
    tick(1);
    i_start = 1'b0;
    wait_until(s + 3 + LAT);
    rstn = 1'b0;
    #1;
    check("rst_async_outs", all_outs(), 0);
    tick(2);
    rstn = 1'b1;
    tick(12);
    check_drained("rst_mid");

    tile("after_rst", 4, 0, 0, 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mac_bank_seq.md
Name: mac_bank_seq

Overview:
- Sequencer for the 4-pixel x 9-tap MAC bank. Per output tile it clears the accumulators, then streams input channels from the activation/weight buffers.
- Drives the accumulate-enable pulses, aligned to the datapath latency.
- Hands the four accumulated output pixels to the next layer, one per valid/ready handshake.
- Sits between the layer control FSM (start/done) and the mac_bank datapath plus its input buffers.

Parameters:
CH_W, 8, width of channel count and buffer read address
RD_LAT, 1, cycles from o_buf_rd_en to data/weight valid at the MAC bank inputs
MAC_LAT, 3, cycles from MAC bank inputs to accumulator update
LAT, RD_LAT+MAC_LAT (derived, not overridable), total issue-to-accumulate delay

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
i_start  in  1  tile start pulse; honoured only in IDLE
i_num_ch  in  CH_W  channels to accumulate; sampled on accepted start
i_feed_hold  in  1  buffer not ready; suppresses issue in FEED
o_busy  out  1  high in every state except IDLE
o_cfg_err  out  1  1-cycle pulse: start with i_num_ch==0
o_buf_rd_en  out  1  buffer read strobe, one channel per cycle
o_buf_rd_addr  out  CH_W  channel index being read
o_acc_clr  out  1  1-cycle accumulator clear
o_acc_en  out  1  accumulate enable, o_buf_rd_en delayed by LAT
o_out_valid  out  1  output pixel valid
i_out_ready  in  1  downstream accepts pixel
o_out_sel  out  2  output pixel index 0..3
o_done  out  1  1-cycle pulse after last pixel accepted

Behaviour:
- Reset: every output 0, FSM in IDLE, channel counter 0, latched count 0, delay line cleared. Reset is async and takes effect mid-operation with no completion or done pulse.
- States: IDLE, CLEAR, FEED, DRAIN, OUT, DONE.
- IDLE:
  - i_start & i_num_ch!=0: latch count N, go to CLEAR.
  - i_start & i_num_ch==0: o_cfg_err=1 next cycle; stay in IDLE.
- CLEAR: o_acc_clr=1 for exactly one cycle; counter reset to 0; go to FEED.
- FEED:
  - Each cycle with i_feed_hold=0: o_buf_rd_en=1, o_buf_rd_addr=counter, counter+1.
  - With i_feed_hold=1: rd_en=0 and counter holds.
  - After issuing addr N-1, go to DRAIN. Counter does not wrap; N=2^CH_W-1 is the maximum.
- Delay line: LAT-deep shift register fed by o_buf_rd_en; o_acc_en is its last stage. Holds propagate as gaps; there is no other acc_en source.
- DRAIN: no issue. Go to OUT in the cycle after the final o_acc_en, i.e. when the delay line is empty.
- OUT:
  - o_out_valid=1, starting with o_out_sel=0.
  - Handshake = valid & ready. It advances sel by 1; valid stays high between pixels.
  - Handshake at sel=3 goes to DONE.
  - sel and valid must stay stable while ready=0.
- DONE: o_done=1 for one cycle, then IDLE. o_busy drops the same cycle o_done drops.
- Simultaneous events:
  - i_start while busy (including during DONE) is ignored and does not raise o_cfg_err.
  - i_feed_hold outside FEED has no effect.
  - i_out_ready outside OUT has no effect.
- Invariants:
  - o_acc_clr and o_acc_en are never high in the same cycle.
  - The count of acc_en pulses per tile equals N exactly.
  - No rd_en occurs outside FEED.

Test Plan:
- N=4, hold=0, ready=1, defaults (LAT=4); start at cycle 0 -> clr cycle 1; rd_en cycles 2-5 with addr 0,1,2,3; acc_en cycles 6-9; out_valid cycles 10-13 with sel 0..3; done cycle 14; busy cycles 1-14.
- N=3, hold high cycles 3-4 -> rd_en cycles 2,5,6 (addr 0,1,2); acc_en cycles 6,9,10; out_valid from cycle 11.
- N=2, ready low for 3 cycles at sel=1 -> sel stays 1 and valid stays high during the stall; done 1 cycle after the sel=3 handshake.
- start with i_num_ch=0 -> o_cfg_err pulse next cycle; busy stays 0; no clr/rd_en.
- start pulsed mid-FEED and during DONE -> ignored; tile finishes with exactly N acc_en; no second tile.
- rstn asserted during DRAIN with acc_en pending -> all outputs 0 immediately; no further acc_en/done after release; a fresh start then runs the nominal sequence.
